// File: rtl/fabric_cfg_pkg.sv
// Shared types and sizing helpers for the fabric configuration loader.
// Also used by fabric bring-up code that needs the image length.
package fabric_cfg_pkg;

  localparam logic [15:0] CFG_MAGIC  = 16'hC0DE;
  localparam int          CFG_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    DONE,
    ERR
  } cfg_state_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_LUT,
    TGT_SW
  } cfg_tgt_e;

  // Image length in words: two per LUT (mem[31:0], then mem[32]) plus one per switch.
  function automatic int cfg_total(input int num_lut, input int num_sw);
    return 2 * num_lut + num_sw;
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/fabric_cfg_loader_if.sv
// Stream-in / fabric-write-port bundle of the configuration loader.
// master = configuration source and fabric side, slave = loader.
interface fabric_cfg_loader_if
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_LUT = 14,
  parameter int NUM_SW  = 22
);
  localparam int LUT_SEL_W = sel_w(NUM_LUT);
  localparam int SW_SEL_W  = sel_w(NUM_SW);

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [CFG_DATA_W-1:0] in_data;
  logic                  lut_we;
  logic [LUT_SEL_W-1:0]  lut_sel;
  logic                  lut_word;
  logic                  sw_we;
  logic [SW_SEL_W-1:0]   sw_sel;
  logic [CFG_DATA_W-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  fabric_enable;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, lut_we, lut_sel, lut_word, sw_we, sw_sel, wr_data,
    input  busy, done, error, fabric_enable
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, lut_we, lut_sel, lut_word, sw_we, sw_sel, wr_data,
    output busy, done, error, fabric_enable
  );

endinterface

// File: rtl/cfg_addr_decode.sv
// Combinational map from image word index to fabric write target.
// Indices at or beyond the image length decode to TGT_NONE.
module cfg_addr_decode
  import fabric_cfg_pkg::*;
#(
  parameter  int NUM_LUT   = 14,
  parameter  int NUM_SW    = 22,
  localparam int TOTAL     = cfg_total(NUM_LUT, NUM_SW),
  localparam int CNT_W     = cnt_w(TOTAL),
  localparam int LUT_SEL_W = sel_w(NUM_LUT),
  localparam int SW_SEL_W  = sel_w(NUM_SW)
) (
  input  logic [CNT_W-1:0]     idx_i,
  output logic [LUT_SEL_W-1:0] lut_sel_o,
  output logic                 lut_word_o,
  output logic [SW_SEL_W-1:0]  sw_sel_o,
  output cfg_tgt_e             tgt_o
);

  localparam logic [CNT_W-1:0] LUT_WORDS_C = CNT_W'(2 * NUM_LUT);
  localparam logic [CNT_W-1:0] TOTAL_C     = CNT_W'(TOTAL);

  always_comb begin
    lut_sel_o  = '0;
    lut_word_o = 1'b0;
    sw_sel_o   = '0;
    tgt_o      = TGT_NONE;
    if (idx_i < LUT_WORDS_C) begin
      tgt_o      = TGT_LUT;
      lut_sel_o  = LUT_SEL_W'(idx_i >> 1);
      lut_word_o = idx_i[0];
    end else if (idx_i < TOTAL_C) begin
      tgt_o    = TGT_SW;
      sw_sel_o = SW_SEL_W'(idx_i - LUT_WORDS_C);
    end
  end

endmodule

// File: rtl/fabric_cfg_loader.sv
// Header-checked streaming loader writing LUT and switch configuration words into the fabric.
// Optional trailer checksum stage enabled by defining CFG_CHECKSUM_EN.
module fabric_cfg_loader
  import fabric_cfg_pkg::*;
#(
  parameter int          NUM_LUT = 14,
  parameter int          NUM_SW  = 22,
  parameter int          SW_W    = 32,
  parameter logic [15:0] MAGIC   = CFG_MAGIC
) (
  input  logic         clock,
  input  logic         reset_n,
  fabric_cfg_loader_if.slave cfg
);

  localparam int TOTAL     = cfg_total(NUM_LUT, NUM_SW);
  localparam int CNT_W     = cnt_w(TOTAL);
  localparam int LUT_SEL_W = sel_w(NUM_LUT);
  localparam int SW_SEL_W  = sel_w(NUM_SW);

  localparam logic [CNT_W-1:0]      LAST_C    = CNT_W'(TOTAL - 1);
  localparam logic [CFG_DATA_W-1:0] HDR_C     = {MAGIC, 16'(TOTAL)};
  localparam logic [CFG_DATA_W-1:0] SW_MASK_C = 32'((64'd1 << SW_W) - 64'd1);

  cfg_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   in_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic                   fen_q;
  logic                   lut_we_q;
  logic [LUT_SEL_W-1:0]   lut_sel_q;
  logic                   lut_word_q;
  logic                   sw_we_q;
  logic [SW_SEL_W-1:0]    sw_sel_q;
  logic [CFG_DATA_W-1:0]  wr_data_q;
  logic [CFG_DATA_W-1:0]  wr_data_d;
`ifdef CFG_CHECKSUM_EN
  logic [CFG_DATA_W-1:0]  sum_q;
  logic [CFG_DATA_W-1:0]  sum_d;
`endif

  logic                   accept;
  logic [LUT_SEL_W-1:0]   dec_lut_sel;
  logic                   dec_lut_word;
  logic [SW_SEL_W-1:0]    dec_sw_sel;
  cfg_tgt_e               dec_tgt;

  cfg_addr_decode #(
    .NUM_LUT (NUM_LUT),
    .NUM_SW  (NUM_SW)
  ) u_decode (
    .idx_i      (cnt_q),
    .lut_sel_o  (dec_lut_sel),
    .lut_word_o (dec_lut_word),
    .sw_sel_o   (dec_sw_sel),
    .tgt_o      (dec_tgt)
  );

  assign accept    = cfg.in_valid & in_ready_q;
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign wr_data_d = (dec_tgt == TGT_SW) ? (cfg.in_data & SW_MASK_C) : cfg.in_data;
`ifdef CFG_CHECKSUM_EN
  assign sum_d     = sum_q + cfg.in_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      fen_q      <= 1'b0;
      lut_we_q   <= 1'b0;
      lut_sel_q  <= '0;
      lut_word_q <= 1'b0;
      sw_we_q    <= 1'b0;
      sw_sel_q   <= '0;
      wr_data_q  <= '0;
`ifdef CFG_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      lut_we_q <= 1'b0;
      sw_we_q  <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (cfg.start) begin
            state_q    <= HDR;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            fen_q      <= 1'b0;
          end else if (state_q == DONE && !done_q) begin
            // Raised one cycle after entry so the last write has landed first.
            done_q <= 1'b1;
            fen_q  <= 1'b1;
          end
        end
        HDR: begin
          if (accept) begin
            if (cfg.in_data == HDR_C) begin
              state_q <= LOAD;
              cnt_q   <= '0;
`ifdef CFG_CHECKSUM_EN
              sum_q   <= '0;
`endif
            end else begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_data_q  <= wr_data_d;
            lut_we_q   <= (dec_tgt == TGT_LUT);
            sw_we_q    <= (dec_tgt == TGT_SW);
            lut_sel_q  <= dec_lut_sel;
            lut_word_q <= dec_lut_word;
            sw_sel_q   <= dec_sw_sel;
`ifdef CFG_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
            if (cnt_q == LAST_C) begin
`ifdef CFG_CHECKSUM_EN
              state_q    <= CHK;
`else
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
`ifdef CFG_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (cfg.in_data == sum_q) begin
              state_q <= DONE;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.in_ready      = in_ready_q;
  assign cfg.lut_we        = lut_we_q;
  assign cfg.lut_sel       = lut_sel_q;
  assign cfg.lut_word      = lut_word_q;
  assign cfg.sw_we         = sw_we_q;
  assign cfg.sw_sel        = sw_sel_q;
  assign cfg.wr_data       = wr_data_q;
  assign cfg.busy          = busy_q;
  assign cfg.done          = done_q;
  assign cfg.error         = error_q;
  assign cfg.fabric_enable = fen_q;

endmodule
